// File: rtl/serial_pkg.sv
// Shared definitions for the serial-link receive/generate stages.
package serial_pkg;

    localparam int unsigned DATA_BITS_DEF  = 8;
    localparam int unsigned PARITY_ODD_DEF = 0;
    // Wide enough to count up to the largest legal DATA_BITS (16).
    localparam int unsigned CNT_W          = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

endpackage

// File: rtl/xor_parity_accum.sv
// 1-bit registered XOR accumulator: p <= clr ? 0 : (en ? p ^ d : p).
module xor_parity_accum (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic p
);

    logic p_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_q <= 1'b0;
        end else if (clr) begin
            p_q <= 1'b0;
        end else if (en) begin
            p_q <= p_q ^ d;
        end
    end

    assign p = p_q;

endmodule

// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start, DATA_BITS data (LSB first), parity, stop.
module serial_parity_rx
    import serial_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
    parameter int unsigned PARITY_ODD = PARITY_ODD_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 done,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam logic PAR_ODD_BIT = (PARITY_ODD != 0);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 rx_par_q, rx_par_d;
    logic                 done_q, done_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 acc_clr, acc_en, acc_p;

    xor_parity_accum u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr),
        .en    (acc_en),
        .d     (bit_in),
        .p     (acc_p)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        data_d   = data_q;
        rx_par_d = rx_par_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        done_d   = 1'b0;
        acc_clr  = 1'b0;
        acc_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bit_valid && !bit_in) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    shift_d = '0;
                    acc_clr = 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_valid) begin
                    // Loop compare avoids indexing with a counter wider than the word.
                    for (int unsigned i = 0; i < DATA_BITS; i++) begin
                        if (cnt_q == CNT_W'(i)) shift_d[i] = bit_in;
                    end
                    acc_en = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_BITS - 1)) state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (bit_valid) begin
                    rx_par_d = bit_in;
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_valid) begin
                    data_d  = shift_q;
                    perr_d  = rx_par_q ^ acc_p ^ PAR_ODD_BIT;
                    ferr_d  = ~bit_in;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            rx_par_q <= 1'b0;
            done_q   <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            rx_par_q <= rx_par_d;
            done_q   <= done_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
        end
    end

    assign data_out   = data_q;
    assign done       = done_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed bench for serial_parity_rx: even-parity and odd-parity instances.
module tb_serial_parity_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       bit_e, val_e, bit_o, val_o;
    logic [7:0] data_e, data_o;
    logic       done_e, perr_e, ferr_e, busy_e;
    logic       done_o, perr_o, ferr_o, busy_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt_e = 0;
    int done_cnt_o = 0;
    int t_last_o = 0;
    int t_prev_o = 0;

    always #5 clk = ~clk;

    serial_parity_rx #(.DATA_BITS(8), .PARITY_ODD(0)) dut_even (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_in     (bit_e),
        .bit_valid  (val_e),
        .data_out   (data_e),
        .done       (done_e),
        .parity_err (perr_e),
        .frame_err  (ferr_e),
        .busy       (busy_e)
    );

    serial_parity_rx #(.DATA_BITS(8), .PARITY_ODD(1)) dut_odd (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_in     (bit_o),
        .bit_valid  (val_o),
        .data_out   (data_o),
        .done       (done_o),
        .parity_err (perr_o),
        .frame_err  (ferr_o),
        .busy       (busy_o)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done_e) done_cnt_e++;
        if (done_o) begin
            done_cnt_o++;
            t_prev_o = t_last_o;
            t_last_o = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input int sel, input logic b, input logic v);
        if (sel == 0) begin
            bit_e = b;
            val_e = v;
        end else begin
            bit_o = b;
            val_o = v;
        end
        @(posedge clk);
        #1;
    endtask

    // Start, 8 data bits LSB first, parity, stop; 'gap' invalid cycles after each bit.
    task automatic send_frame(input int sel, input logic [7:0] d, input logic par,
                              input logic stop, input int gap);
        logic [10:0] bits;
        bits = {stop, par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            send_bit(sel, bits[i], 1'b1);
            if (i == 10) break;
            for (int g = 0; g < gap; g++) send_bit(sel, 1'b1, 1'b0);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        bit_e = 1'b1; val_e = 1'b0;
        bit_o = 1'b1; val_o = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 32'(data_e), 32'h0);
        check("rst_flags", {28'd0, done_e, perr_e, ferr_e, busy_e}, 32'h0);
        rst_n = 1'b1;
        send_bit(0, 1'b1, 1'b0);

        // 0xA5, four ones: even parity bit 0
        send_frame(0, 8'hA5, 1'b0, 1'b1, 0);
        check("a5_done", 32'(done_e), 32'h1);
        check("a5_data", 32'(data_e), 32'hA5);
        check("a5_flags", {29'd0, perr_e, ferr_e, busy_e}, 32'h0);
        send_bit(0, 1'b1, 1'b0);
        check("a5_done_1cyc", 32'(done_e), 32'h0);
        check("a5_data_held", 32'(data_e), 32'hA5);

        send_frame(0, 8'hA5, 1'b1, 1'b1, 0);
        check("perr_data", 32'(data_e), 32'hA5);
        check("perr_flags", {30'd0, perr_e, ferr_e}, 32'h2);

        send_frame(0, 8'hA5, 1'b0, 1'b0, 0);
        check("ferr_data", 32'(data_e), 32'hA5);
        check("ferr_flags", {30'd0, perr_e, ferr_e}, 32'h1);
        send_bit(0, 1'b1, 1'b0);
        check("ferr_flags_held", {30'd0, perr_e, ferr_e}, 32'h1);

        // 0x3C with idle 1s and 3-cycle gaps
        for (int i = 0; i < 3; i++) send_bit(0, 1'b1, 1'b1);
        check("idle_not_busy", 32'(busy_e), 32'h0);
        n = done_cnt_e;
        send_frame(0, 8'h3C, 1'b0, 1'b1, 3);
        check("gap_done_cnt", 32'(done_cnt_e - n), 32'h0);
        check("gap_done", 32'(done_e), 32'h1);
        check("gap_data", 32'(data_e), 32'h3C);
        check("gap_flags", {30'd0, perr_e, ferr_e}, 32'h0);

        // Abort mid-frame with reset
        send_bit(0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(0, 1'b1, 1'b1);
        check("mid_busy", 32'(busy_e), 32'h1);
        rst_n = 1'b0;
        send_bit(0, 1'b1, 1'b0);
        rst_n = 1'b1;
        check("abort_data", 32'(data_e), 32'h0);
        check("abort_flags", {28'd0, done_e, perr_e, ferr_e, busy_e}, 32'h0);
        n = done_cnt_e;
        send_frame(0, 8'h01, 1'b1, 1'b1, 0);
        check("post_rst_data", 32'(data_e), 32'h01);
        check("post_rst_flags", {30'd0, perr_e, ferr_e}, 32'h0);
        send_bit(0, 1'b1, 1'b0);
        check("post_rst_one_done", 32'(done_cnt_e - n), 32'h1);

        // Odd parity, back-to-back: second start bit driven in the done cycle
        send_frame(1, 8'h00, 1'b1, 1'b1, 0);
        check("odd0_done", 32'(done_o), 32'h1);
        check("odd0_data", 32'(data_o), 32'h00);
        check("odd0_perr", 32'(perr_o), 32'h0);
        send_frame(1, 8'hFF, 1'b1, 1'b1, 0);
        check("oddff_done", 32'(done_o), 32'h1);
        check("oddff_data", 32'(data_o), 32'hFF);
        check("oddff_perr", 32'(perr_o), 32'h0);
        send_bit(1, 1'b1, 1'b0);
        check("odd_done_cnt", 32'(done_cnt_o), 32'h2);
        // 11-bit frame with no dead cycle: pulses 11 clocks apart
        check("odd_spacing", 32'(t_last_o - t_prev_o), 32'd11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
